// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the button conditioner: per-channel FSM state
// encoding, debounce/repeat counter width and default timing constants.
package btn_conditioner_pkg;

  // Width of the per-channel debounce / auto-repeat counter
  localparam int CNT_W = 16;

  // Default channel count and timings, expressed in TICKs of the ~30.5 kHz strobe
  localparam int DEF_N_BTN          = 2;
  localparam int DEF_DEBOUNCE_TICKS = 600;
  localparam int DEF_REPEAT_DELAY   = 15259;
  localparam int DEF_REPEAT_RATE    = 3052;

  // Per-channel FSM states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE        = 2'b00,
    ST_DEB_PRESS   = 2'b01,
    ST_PRESSED     = 2'b10,
    ST_DEB_RELEASE = 2'b11
  } btn_state_t;

  typedef logic [CNT_W-1:0] btn_cnt_t;

  // Converts an integer timing parameter into a counter compare value
  function automatic btn_cnt_t to_cnt(input int value);
    return btn_cnt_t'(value);
  endfunction

  // The debounced level is high whenever the button is considered held
  function automatic logic level_of(input btn_state_t st);
    return (st == ST_PRESSED) || (st == ST_DEB_RELEASE);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debounce/auto-repeat FSM with a
// shared 16-bit counter, and registered level/press/repeat/release outputs.
// REPEAT_DELAY must be at least REPEAT_RATE (the counter is reloaded with
// their difference after each repeat so it never runs past REPEAT_DELAY-1).
module btn_channel
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE    = DEF_REPEAT_RATE,
  parameter bit REPEAT_EN      = 1'b1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic TICK,
  input  logic BTN_IN,
  output logic BTN_LEVEL,
  output logic BTN_PRESS,
  output logic BTN_REPEAT,
  output logic BTN_RELEASE
);

  localparam btn_cnt_t DEB_LAST   = to_cnt(DEBOUNCE_TICKS - 1);
  localparam btn_cnt_t REP_LAST   = to_cnt(REPEAT_DELAY - 1);
  localparam btn_cnt_t REP_RELOAD = to_cnt(REPEAT_DELAY - REPEAT_RATE);

  logic       sync_meta;
  logic       sync_level;
  btn_state_t state;
  btn_state_t next_state;
  btn_cnt_t   cnt;
  btn_cnt_t   next_cnt;
  logic       level_d;
  logic       press_d;
  logic       repeat_d;
  logic       release_d;

  // Two-flop synchronizer bringing the raw button level into the CLK domain
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_meta  <= 1'b0;
      sync_level <= 1'b0;
    end else begin
      sync_meta  <= BTN_IN;
      sync_level <= sync_meta;
    end
  end

  // State and counter register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Next-state and counter logic; a level change always wins over a same-cycle TICK
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      ST_IDLE: begin
        if (sync_level) begin
          next_state = ST_DEB_PRESS;
          next_cnt   = '0;
        end
      end
      ST_DEB_PRESS: begin
        if (!sync_level) begin
          next_state = ST_IDLE;
          next_cnt   = '0;
        end else if (TICK) begin
          if (cnt == DEB_LAST) begin
            next_state = ST_PRESSED;
            next_cnt   = '0;
          end else begin
            next_cnt = cnt + 1'b1;
          end
        end
      end
      ST_PRESSED: begin
        if (!sync_level) begin
          next_state = ST_DEB_RELEASE;
          next_cnt   = '0;
        end else if (TICK && REPEAT_EN) begin
          if (cnt == REP_LAST) begin
            next_cnt = REP_RELOAD;
          end else begin
            next_cnt = cnt + 1'b1;
          end
        end
      end
      ST_DEB_RELEASE: begin
        if (sync_level) begin
          next_state = ST_PRESSED;
          next_cnt   = '0;
        end else if (TICK) begin
          if (cnt == DEB_LAST) begin
            next_state = ST_IDLE;
            next_cnt   = '0;
          end else begin
            next_cnt = cnt + 1'b1;
          end
        end
      end
      default: begin
        next_state = ST_IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // Output decode from the transition about to be taken
  always_comb begin
    level_d   = level_of(next_state);
    press_d   = (state == ST_DEB_PRESS) && (next_state == ST_PRESSED);
    release_d = (state == ST_DEB_RELEASE) && (next_state == ST_IDLE);
    repeat_d  = (state == ST_PRESSED) && sync_level && TICK && REPEAT_EN &&
                (cnt == REP_LAST);
  end

  // Registered outputs so pulses and level change together, one CLK after the decision
  always_ff @(posedge CLK) begin
    if (RESET) begin
      BTN_LEVEL   <= 1'b0;
      BTN_PRESS   <= 1'b0;
      BTN_REPEAT  <= 1'b0;
      BTN_RELEASE <= 1'b0;
    end else begin
      BTN_LEVEL   <= level_d;
      BTN_PRESS   <= press_d;
      BTN_REPEAT  <= repeat_d;
      BTN_RELEASE <= release_d;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Button conditioner top: N_BTN fully independent btn_channel instances.
// Channel 0 is DEC, channel 1 is btn_switch.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int               N_BTN          = DEF_N_BTN,
  parameter int               DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int               REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int               REPEAT_RATE    = DEF_REPEAT_RATE,
  parameter logic [N_BTN-1:0] REPEAT_MASK    = {N_BTN{1'b1}}
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             TICK,
  input  logic [N_BTN-1:0] BTN_IN,
  output logic [N_BTN-1:0] BTN_LEVEL,
  output logic [N_BTN-1:0] BTN_PRESS,
  output logic [N_BTN-1:0] BTN_REPEAT,
  output logic [N_BTN-1:0] BTN_RELEASE
);

  // One conditioner per button; auto-repeat is enabled per channel by REPEAT_MASK
  for (genvar ch = 0; ch < N_BTN; ch++) begin : g_channel
    btn_channel #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_RATE   (REPEAT_RATE),
      .REPEAT_EN     (REPEAT_MASK[ch])
    ) u_channel (
      .CLK        (CLK),
      .RESET      (RESET),
      .TICK       (TICK),
      .BTN_IN     (BTN_IN[ch]),
      .BTN_LEVEL  (BTN_LEVEL[ch]),
      .BTN_PRESS  (BTN_PRESS[ch]),
      .BTN_REPEAT (BTN_REPEAT[ch]),
      .BTN_RELEASE(BTN_RELEASE[ch])
    );
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 N_BTN, 2, number of button channels; channel 0 is DEC, channel 1 is btn_switch.
REQ-002 DEBOUNCE_TICKS, 600, stable-level TICK count required to accept an edge (about 20 ms at 30.5 kHz).
REQ-003 REPEAT_DELAY, 15259, TICKs from accepted press to first auto-repeat (about 0.5 s).
REQ-004 REPEAT_RATE, 3052, TICKs between subsequent auto-repeats (about 100 ms).
REQ-005 REPEAT_MASK, {N_BTN{1'b1}}, per-channel auto-repeat enable.
REQ-006 CLK  in  1  system clock (125 MHz).
REQ-007 RESET  in  1  reset, synchronous to CLK, active-high.
REQ-008 TICK  in  1  single-CLK strobe: the ENABLE_kHz pulse, asserted when tmp_count[11:0]==12'hfff.
REQ-009 BTN_IN  in  N_BTN  raw, asynchronous button levels, active-high.
REQ-010 BTN_LEVEL  out  N_BTN  debounced level per channel.
REQ-011 BTN_PRESS  out  N_BTN  one-CLK pulse on each accepted press.
REQ-012 BTN_REPEAT  out  N_BTN  one-CLK pulse per auto-repeat while held.
REQ-013 BTN_RELEASE  out  N_BTN  one-CLK pulse on each accepted release.

Function
REQ-014 Each BTN_IN bit SHALL pass through a 2-flop synchronizer; the FSM sees the second-flop value (SYNC).
REQ-015 Each channel SHALL run an independent FSM with states IDLE, DEB_PRESS, PRESSED, DEB_RELEASE and one 16-bit debounce/repeat counter.
REQ-016 In IDLE with SYNC=1, the FSM SHALL go to DEB_PRESS and clear the counter.
REQ-017 In DEB_PRESS with SYNC=0, the FSM SHALL return to IDLE and emit no pulse.
REQ-018 In DEB_PRESS with SYNC=1, the counter SHALL increment on each TICK; on the TICK at which the counter equals DEBOUNCE_TICKS-1, the FSM SHALL go to PRESSED and assert BTN_PRESS for the next CLK cycle.
REQ-019 In PRESSED with SYNC=0, the FSM SHALL go to DEB_RELEASE and clear the counter.
REQ-020 In PRESSED with SYNC=1 and the mask bit set, the counter SHALL count TICKs:
- one BTN_REPEAT pulse after REPEAT_DELAY TICKs;
- thereafter one pulse every REPEAT_RATE TICKs, indefinitely;
- no counter overflow.
REQ-021 In DEB_RELEASE with SYNC=1, the FSM SHALL return to PRESSED with no pulse, and the repeat timing SHALL restart from REPEAT_DELAY.
REQ-022 In DEB_RELEASE with SYNC=0, after DEBOUNCE_TICKS TICKs the FSM SHALL go to IDLE and assert BTN_RELEASE for one CLK.
REQ-023 BTN_LEVEL SHALL be 1 in PRESSED and DEB_RELEASE and 0 otherwise, and SHALL change in the same cycle as the BTN_PRESS/BTN_RELEASE pulse.
REQ-024 When a SYNC change and a TICK occur in the same cycle, the SYNC change SHALL take priority: the counter clears and no pulse is emitted.
REQ-025 All outputs SHALL be registered; BTN_PRESS, BTN_REPEAT and BTN_RELEASE SHALL never be asserted for more than one CLK cycle, and never two of them on one channel in the same cycle.
REQ-026 Channels SHALL not interact; simultaneous activity on all channels SHALL be handled independently.

Reset
REQ-027 On RESET=1 at a CLK edge:
- synchronizer flops, counters and outputs SHALL go to 0;
- every FSM SHALL go to IDLE.
REQ-028 RESET asserted mid-press SHALL drop BTN_LEVEL to 0 with no BTN_RELEASE pulse.
REQ-029 A button still held after RESET deasserts SHALL be re-debounced from IDLE and SHALL produce one BTN_PRESS after DEBOUNCE_TICKS TICKs.

Structure
REQ-030 A shared include file SHALL hold the FSM state localparams (2-bit encoding) and the 16-bit counter width constant.
REQ-031 The block SHALL consist of a generate loop of N_BTN instances of the sub-module btn_channel (synchronizer, FSM and counter); btn_conditioner contains no other logic.

Verification (DEBOUNCE_TICKS=4, REPEAT_DELAY=8, REPEAT_RATE=3, TICK every 4 CLK)
REQ-032 Clean press, then release after 40 TICKs:
- exactly one BTN_PRESS after 4 TICKs;
- BTN_REPEAT at TICK 8 after the press, then at TICKs 11, 14, 17 and every 3 TICKs after;
- one BTN_RELEASE 4 TICKs after the release.
REQ-033 Bounce of 1-TICK pulses for 3 TICKs, then stable high -> no pulses during the bounce; one BTN_PRESS 4 TICKs after the level stabilises.
REQ-034 A 2-TICK low glitch while PRESSED -> no BTN_RELEASE, BTN_LEVEL stays 1, first repeat arrives 8 TICKs after the glitch ends.
REQ-035 RESET for 1 CLK while held in PRESSED:
- BTN_LEVEL goes 0 with no BTN_RELEASE;
- one BTN_PRESS 4 TICKs after RESET deasserts.
REQ-036 REPEAT_MASK=2'b01, both buttons held 20 TICKs -> repeats only on channel 0; channel 1 gives PRESS and RELEASE only.
REQ-037 SYNC rises in the same cycle as a TICK -> the counter starts at 0 and BTN_PRESS lands on the 4th following TICK, not the 3rd.
